bit_generating: RTL and testbench

Inverse of the bit-counting datapath. Takes a ones-count N and serially builds a WIDTH-bit word containing exactly N ones, shifting one bit per clock, then presents the word with a start/done handshake. Used as a stimulus/pattern source feeding the counting path, and wherever a thermometer-coded mask is needed from a binary count.

---
 rtl/bit_generating_pkg.sv | 20 ++
 rtl/bit_gen_shifter.sv | 33 +++
 rtl/bit_generating.sv | 83 ++++++++
 tb/tb_bit_generating.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/bit_generating_pkg.sv
// Shared types and helpers for the serial ones-pattern generator.
// Holds the FSM encoding, the count-width rule and ones-count saturation.
package bit_generating_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01,
        FINISH = 2'b10
    } state_t;

    // Bits needed to hold a count in 0..w inclusive.
    function automatic int cw_of(input int w);
        return $clog2(w + 1);
    endfunction

    function automatic int sat_count(input int b, input int w);
        return (b > w) ? w : b;
    endfunction

endpackage

// File: rtl/bit_gen_shifter.sv
// WIDTH-bit shift register that inserts a 1 per enabled cycle from the selected end.
// Exposes the shifted value so the owner can capture it on the final edge.
module bit_gen_shifter #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic             clr,
    input  logic             shift_en,
    output logic [WIDTH-1:0] sh_next
);

    logic [WIDTH-1:0] sh;

    generate
        if (MSB_FIRST) begin : g_msb
            assign sh_next = {1'b1, sh[WIDTH-1:1]};
        end else begin : g_lsb
            assign sh_next = {sh[WIDTH-2:0], 1'b1};
        end
    endgenerate

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ACLK) begin
        if (!ARESETN || clr) begin
            sh <= '0;
        end else if (shift_en) begin
            sh <= sh_next;
        end
    end

endmodule

// File: rtl/bit_generating.sv
// Builds a WIDTH-bit word holding exactly min(B, WIDTH) ones, one bit per clock,
// and presents it with a level start / registered done handshake.
module bit_generating
    import bit_generating_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CW        = cw_of(WIDTH),
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic             start,
    input  logic             LoadB,
    input  logic [CW-1:0]    B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] A
);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    ns;
    logic [WIDTH-1:0] sh_next;
    logic             load;
    logic             last_shift;

    assign ns         = CW'(sat_count(int'(B), WIDTH));
    assign load       = (state_q == IDLE) && start && LoadB;
    assign last_shift = (state_q == SHIFT) && (cnt == CW'(1));
    assign busy       = (state_q == SHIFT);

    bit_gen_shifter #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shifter (
        .ACLK     (ACLK),
        .ARESETN  (ARESETN),
        .clr      (load),
        .shift_en (busy),
        .sh_next  (sh_next)
    );

    // NOTE: next state gets a default first so no path through the case can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (load) state_d = (ns != '0) ? SHIFT : FINISH;
            end
            SHIFT: begin
                if (cnt == CW'(1)) state_d = FINISH;
            end
            FINISH: begin
                if (!start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q <= IDLE;
            cnt     <= '0;
            done    <= 1'b0;
            A       <= '0;
        end else begin
            state_q <= state_d;
            done    <= (state_d == FINISH);
            if (load) begin
                cnt <= ns;
            end else if (busy) begin
                cnt <= cnt - CW'(1);
            end
            // A moves only on the edge that enters FINISH, together with done.
            if (load && ns == '0) begin
                A <= '0;
            end else if (last_shift) begin
                A <= sh_next;
            end
        end
    end

endmodule

// File: tb/tb_bit_generating.sv
// Randomized self-checking bench for bit_generating; LSB-first and MSB-first
// instances share stimulus and are compared against an arithmetic reference.
module tb_bit_generating;

    localparam int WIDTH = 8;
    localparam int CW    = 4;

    logic             ACLK;
    logic             ARESETN;
    logic             start;
    logic             LoadB;
    logic [CW-1:0]    B;
    logic             busy0, done0, busy1, done1;
    logic [WIDTH-1:0] a0, a1;

    int n_checks = 0;
    int n_pass   = 0;
    logic [WIDTH-1:0] last_a0, last_a1;

    bit_generating #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
        .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .LoadB(LoadB), .B(B),
        .busy(busy0), .done(done0), .A(a0)
    );

    bit_generating #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_msb (
        .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .LoadB(LoadB), .B(B),
        .busy(busy1), .done(done1), .A(a1)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference: N ones packed against the chosen end of the word.
    function automatic logic [WIDTH-1:0] ref_word(input int b, input bit msb_first);
        int n;
        logic [WIDTH-1:0] w;
        n = (b > WIDTH) ? WIDTH : b;
        w = '0;
        for (int i = 0; i < n; i++) begin
            if (msb_first) w[WIDTH-1-i] = 1'b1;
            else           w[i]         = 1'b1;
        end
        return w;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, {31'b0, busy0 | busy1}, 32'd0);
        check({tag, "_done"}, {31'b0, done0 | done1}, 32'd0);
        check({tag, "_a_lsb"}, {24'b0, a0}, {24'b0, last_a0});
        check({tag, "_a_msb"}, {24'b0, a1}, {24'b0, last_a1});
    endtask

    // One full request: drives start/LoadB/B, follows the exact latency, holds start
    // in FINISH for `hold` cycles, then drops it and confirms return to IDLE.
    task automatic run_req(input string tag, input int b, input int hold, input bit mangle);
        int n;
        logic [WIDTH-1:0] exp0, exp1;
        n    = (b > WIDTH) ? WIDTH : b;
        exp0 = ref_word(b, 1'b0);
        exp1 = ref_word(b, 1'b1);
        @(negedge ACLK);
        start = 1'b1; LoadB = 1'b1; B = CW'(b);
        @(negedge ACLK);
        for (int i = 0; i < n; i++) begin
            check({tag, "_busy"}, {31'b0, busy0 & busy1}, 32'd1);
            check({tag, "_nodone"}, {31'b0, done0 | done1}, 32'd0);
            if (mangle) begin
                B = CW'($urandom_range(0, 15));
                LoadB = 1'($urandom);
            end
            @(negedge ACLK);
        end
        check({tag, "_done"}, {30'b0, done0, done1}, 32'd3);
        check({tag, "_busy_clr"}, {31'b0, busy0 | busy1}, 32'd0);
        check({tag, "_a_lsb"}, {24'b0, a0}, {24'b0, exp0});
        check({tag, "_a_msb"}, {24'b0, a1}, {24'b0, exp1});
        for (int i = 0; i < hold; i++) begin
            LoadB = 1'b1;
            B = CW'($urandom_range(0, 15));
            @(negedge ACLK);
            check({tag, "_hold_done"}, {30'b0, done0, done1}, 32'd3);
            check({tag, "_hold_busy"}, {31'b0, busy0 | busy1}, 32'd0);
            check({tag, "_hold_a"}, {16'b0, a0, a1}, {16'b0, exp0, exp1});
        end
        start = 1'b0; LoadB = 1'b0;
        last_a0 = exp0;
        last_a1 = exp1;
        @(negedge ACLK);
        check_idle({tag, "_release"});
    endtask

    initial begin
        start = 1'b0; LoadB = 1'b0; B = '0; ARESETN = 1'b0;
        last_a0 = '0; last_a1 = '0;
        repeat (2) @(negedge ACLK);
        check_idle("reset");
        ARESETN = 1'b1;
        repeat (3) @(negedge ACLK);
        check_idle("idle");

        run_req("b5", 5, 2, 1'b0);
        run_req("b0", 0, 1, 1'b0);
        run_req("b8", 8, 0, 1'b0);
        run_req("b12", 12, 0, 1'b0);
        run_req("b3", 3, 0, 1'b0);
        run_req("b1", 1, 0, 1'b0);

        // start without LoadB must be ignored in IDLE.
        start = 1'b1; LoadB = 1'b0; B = 4'd7;
        repeat (3) begin
            @(negedge ACLK);
            check_idle("noload");
        end
        start = 1'b0;
        @(negedge ACLK);

        run_req("b3_mangle", 3, 0, 1'b1);
        run_req("hold_long", 4, 4, 1'b0);

        for (int t = 0; t < 20; t++) begin
            run_req("rand", int'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                    1'($urandom));
        end

        // Reset in the middle of a SHIFT run discards the partial result.
        @(negedge ACLK);
        start = 1'b1; LoadB = 1'b1; B = 4'd6;
        repeat (3) @(negedge ACLK);
        check("mid_busy", {31'b0, busy0 & busy1}, 32'd1);
        ARESETN = 1'b0;
        start = 1'b0; LoadB = 1'b0;
        @(negedge ACLK);
        last_a0 = '0; last_a1 = '0;
        check_idle("mid_reset");
        ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);
        check_idle("mid_after");
        run_req("post_b2", 2, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
